// File: rtl/mips_pkg.sv
// Shared types and default widths for the MIPS unified-memory arbiter.
// The optional program loader is enabled with MIPS_MEM_LOADER_EN.
package mips_pkg;

  localparam int MEM_ADDR_W = 10;
  localparam int MEM_DATA_W = 32;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DRAIN,
    ST_LOAD
  } arb_state_e;

  typedef enum logic [1:0] {
    TAG_NONE,
    TAG_IF,
    TAG_DM,
    TAG_LD
  } rd_tag_e;

endpackage

// File: rtl/mips_mem_arbiter_if.sv
// Requester, loader and memory-port bundle for mips_mem_arbiter.
// Loader fields exist only when MIPS_MEM_LOADER_EN is defined.
interface mips_mem_arbiter_if #(
  parameter int ADDR_W = mips_pkg::MEM_ADDR_W,
  parameter int DATA_W = mips_pkg::MEM_DATA_W
);

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_gnt;
  logic              dm_rvalid;
  logic [DATA_W-1:0] dm_rdata;

`ifdef MIPS_MEM_LOADER_EN
  logic              ld_req;
  logic              ld_we;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_wdata;
  logic              ld_gnt;
  logic              ld_rvalid;
  logic [DATA_W-1:0] ld_rdata;
`endif

  logic              ld_active;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

`ifdef MIPS_MEM_LOADER_EN
  modport slave (
    input  if_req, if_addr,
    input  dm_req, dm_we, dm_addr, dm_wdata,
    input  ld_req, ld_we, ld_addr, ld_wdata,
    input  mem_rdata,
    output if_gnt, if_rvalid, if_rdata,
    output dm_gnt, dm_rvalid, dm_rdata,
    output ld_gnt, ld_rvalid, ld_rdata,
    output ld_active,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr,
    output dm_req, dm_we, dm_addr, dm_wdata,
    output ld_req, ld_we, ld_addr, ld_wdata,
    output mem_rdata,
    input  if_gnt, if_rvalid, if_rdata,
    input  dm_gnt, dm_rvalid, dm_rdata,
    input  ld_gnt, ld_rvalid, ld_rdata,
    input  ld_active,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );
`else
  modport slave (
    input  if_req, if_addr,
    input  dm_req, dm_we, dm_addr, dm_wdata,
    input  mem_rdata,
    output if_gnt, if_rvalid, if_rdata,
    output dm_gnt, dm_rvalid, dm_rdata,
    output ld_active,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr,
    output dm_req, dm_we, dm_addr, dm_wdata,
    output mem_rdata,
    input  if_gnt, if_rvalid, if_rdata,
    input  dm_gnt, dm_rvalid, dm_rdata,
    input  ld_active,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );
`endif

endinterface

// File: rtl/mips_starve_ctr.sv
// Saturating 4-bit fetch-starvation counter with clear/increment
// and an at-max flag.
module mips_starve_ctr #(
  parameter int MAX = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic at_max
);

  logic [3:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (inc && cnt_q != 4'(MAX)) begin
      cnt_q <= cnt_q + 4'd1;
    end
  end

  assign at_max = (cnt_q == 4'(MAX));

endmodule

// File: rtl/mips_mem_arbiter.sv
// Unified-memory arbiter for fetch, MEM stage and an optional loader.
// Loader path, DRAIN/LOAD states enabled by MIPS_MEM_LOADER_EN.
module mips_mem_arbiter
  import mips_pkg::*;
#(
  parameter int ADDR_W     = MEM_ADDR_W,
  parameter int DATA_W     = MEM_DATA_W,
  parameter int STARVE_MAX = 3
) (
  input logic               clk,
  input logic               rst_n,
  mips_mem_arbiter_if.slave bus
);

  logic              run_arb;
  logic              cnt_hold;
  logic              at_max;
  logic              if_g;
  logic              dm_g;
  logic              en_c;
  logic              we_c;
  logic [ADDR_W-1:0] addr_c;
  logic [DATA_W-1:0] wdata_c;
  rd_tag_e           tag_q;
  rd_tag_e           tag_d;

`ifdef MIPS_MEM_LOADER_EN
  arb_state_e state_q;
  arb_state_e state_d;
  logic       ld_sel;
  logic       ld_g;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // The LOAD exit cycle (ld_req low) already arbitrates as RUN.
  always_comb begin
    state_d  = state_q;
    run_arb  = 1'b0;
    ld_sel   = 1'b0;
    cnt_hold = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        run_arb = 1'b1;
        if (bus.ld_req) state_d = ST_DRAIN;
      end
      ST_DRAIN: state_d = ST_LOAD;
      ST_LOAD: begin
        if (bus.ld_req) begin
          ld_sel   = 1'b1;
          cnt_hold = 1'b1;
        end else begin
          run_arb = 1'b1;
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  assign ld_g          = rst_n & ld_sel;
  assign bus.ld_gnt    = ld_g;
  assign bus.ld_active = ld_g;
  assign bus.ld_rvalid = (tag_q == TAG_LD);
  assign bus.ld_rdata  = bus.mem_rdata;
`else
  assign run_arb       = 1'b1;
  assign cnt_hold      = 1'b0;
  assign bus.ld_active = 1'b0;
`endif

  assign if_g = rst_n & run_arb & bus.if_req
              & (~bus.dm_req | at_max);
  assign dm_g = rst_n & run_arb & bus.dm_req & ~if_g;

  mips_starve_ctr #(
    .MAX (STARVE_MAX)
  ) u_starve (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (~cnt_hold & (if_g | ~bus.if_req)),
    .inc    (~cnt_hold & bus.if_req & ~if_g),
    .at_max (at_max)
  );

  always_comb begin
    en_c    = 1'b0;
    we_c    = 1'b0;
    addr_c  = '0;
    wdata_c = '0;
    tag_d   = TAG_NONE;
    unique case (1'b1)
      if_g: begin
        en_c   = 1'b1;
        addr_c = bus.if_addr;
        tag_d  = TAG_IF;
      end
      dm_g: begin
        en_c    = 1'b1;
        we_c    = bus.dm_we;
        addr_c  = bus.dm_addr;
        wdata_c = bus.dm_wdata;
        tag_d   = bus.dm_we ? TAG_NONE : TAG_DM;
      end
`ifdef MIPS_MEM_LOADER_EN
      ld_g: begin
        en_c    = 1'b1;
        we_c    = bus.ld_we;
        addr_c  = bus.ld_addr;
        wdata_c = bus.ld_wdata;
        tag_d   = bus.ld_we ? TAG_NONE : TAG_LD;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_q <= TAG_NONE;
    end else begin
      tag_q <= tag_d;
    end
  end

  assign bus.if_gnt    = if_g;
  assign bus.dm_gnt    = dm_g;
  assign bus.mem_en    = en_c;
  assign bus.mem_we    = we_c;
  assign bus.mem_addr  = addr_c;
  assign bus.mem_wdata = wdata_c;

  assign bus.if_rvalid = (tag_q == TAG_IF);
  assign bus.dm_rvalid = (tag_q == TAG_DM);
  assign bus.if_rdata  = bus.mem_rdata;
  assign bus.dm_rdata  = bus.mem_rdata;

endmodule
